// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    // Loader life cycle: wipe memory, accept a program, hold the core, run it.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Defaults matching the original 16-bit, 64-word instruction store.
    localparam int DEF_INSTR_W   = 16;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_OFF_SHIFT = $clog2(DEF_INSTR_W / 8);
    localparam int DEF_PTR_W     = $clog2(DEF_DEPTH);

    localparam logic [DEF_INSTR_W-1:0] NOP_DEFAULT = 16'h0000;

    // Number of byte-offset bits dropped from a fetch address.
    function automatic int off_shift(input int instr_w);
        return $clog2(instr_w / 8);
    endfunction

    // Width of a word pointer into a memory of the given depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction RAM: one write port, one synchronous read port. The read
// register falls back to FILL whenever the read is not enabled, so the
// caller can blank the output without an extra mux stage.
module imem_array #(
    parameter int                 INSTR_W = 16,
    parameter int                 DEPTH   = 64,
    parameter int                 AW      = $clog2(DEPTH),
    parameter logic [INSTR_W-1:0] FILL    = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_r [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end else begin
            rdata <= FILL;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Owns the instruction memory: clears it, loads a program over a
// valid/ready stream, holds the core in reset for a while, then serves
// fetches while the core runs. A reload pulse in RUN starts over.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                 INSTR_W  = 16,
    parameter int                 DEPTH    = 64,
    parameter int                 ADDR_W   = 8,
    parameter int                 RST_HOLD = 2,
    parameter logic [INSTR_W-1:0] NOP_WORD = {INSTR_W{1'b0}}
) (
    input  logic                   clka,
    input  logic                   reset,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INSTR_W-1:0]     ld_data,
    input  logic                   ld_last,
    input  logic                   reload,
    input  logic [ADDR_W-1:0]      fetch_addr,
    output logic [INSTR_W-1:0]     fetch_data,
    output logic                   core_reset,
    output logic                   run,
    output logic [$clog2(DEPTH):0] load_count,
    output logic                   err_overflow
);

    localparam int SHIFT  = off_shift(INSTR_W);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(RST_HOLD - 1);

    state_t              state_r;
    state_t              next_state_s;
    logic [PTR_W-1:0]    clr_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                beat_s;
    logic                last_slot_s;
    logic                mem_we_s;
    logic [PTR_W-1:0]    mem_waddr_s;
    logic [INSTR_W-1:0]  mem_wdata_s;
    logic [ADDR_W:0]     idx_ext_s;
    logic                rd_en_s;

    assign beat_s      = ld_valid & ld_ready & (state_r == ST_LOAD);
    assign last_slot_s = (wr_ptr_r == LAST_SLOT);

    // Fetch index ignores the byte offset; the extra top bit keeps the
    // range check exact even when the address space equals the memory.
    assign idx_ext_s = {1'b0, fetch_addr} >> SHIFT;

    // Next-state decode for the clear/load/hold/run sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_ptr_r == LAST_SLOT) next_state_s = ST_LOAD;
                else                        next_state_s = ST_CLEAR;
            end
            ST_LOAD: begin
                if (beat_s && (ld_last || last_slot_s)) next_state_s = ST_HOLD;
                else                                    next_state_s = ST_LOAD;
            end
            ST_HOLD: begin
                if (hold_cnt_r == HOLD_END) next_state_s = ST_RUN;
                else                        next_state_s = ST_HOLD;
            end
            ST_RUN: begin
                if (reload) next_state_s = ST_CLEAR;
                else        next_state_s = ST_RUN;
            end
            default: next_state_s = ST_CLEAR;
        endcase
    end

    // Memory write port: NOP fill while clearing, stream data on a beat.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_ptr_r;
        mem_wdata_s = NOP_WORD;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s = 1'b1;
        end else if (beat_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_ptr_r;
            mem_wdata_s = ld_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Reads are live only in RUN, in range, and not on the reload cycle.
    always_comb begin
        rd_en_s = 1'b0;
        if (!reset && (state_r == ST_RUN) && !reload &&
            (idx_ext_s < (ADDR_W + 1)'(DEPTH))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // State, pointers, counters and the registered core-facing outputs.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_r      <= ST_CLEAR;
            clr_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
            load_count   <= {CNT_W{1'b0}};
            err_overflow <= 1'b0;
            core_reset   <= 1'b1;
            run          <= 1'b0;
            ld_ready     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            core_reset <= (next_state_s != ST_RUN);
            run        <= (next_state_s == ST_RUN);
            ld_ready   <= (next_state_s == ST_LOAD);

            if ((state_r == ST_RUN) && reload) begin
                clr_ptr_r    <= {PTR_W{1'b0}};
                wr_ptr_r     <= {PTR_W{1'b0}};
                load_count   <= {CNT_W{1'b0}};
                err_overflow <= 1'b0;
            end else begin
                if (state_r == ST_CLEAR) begin
                    clr_ptr_r <= clr_ptr_r + PTR_W'(1);
                end
                if (beat_s) begin
                    wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
                    load_count <= load_count + CNT_W'(1);
                    if (last_slot_s && !ld_last) begin
                        err_overflow <= 1'b1;
                    end
                end
            end

            if (state_r == ST_HOLD) hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            else                    hold_cnt_r <= {HOLD_W{1'b0}};
        end
    end

    imem_array #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .AW      (PTR_W),
        .FILL    (NOP_WORD)
    ) u_array (
        .clk   (clka),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .re    (rd_en_s),
        .raddr (idx_ext_s[PTR_W-1:0]),
        .rdata (fetch_data)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 64-word instance for the main flow and
// a 4-word instance for overflow boundaries, sharing one clock.
module tb_imem_loader;

    logic clk;

    logic        reset, ld_valid, ld_ready, ld_last, reload;
    logic [15:0] ld_data, fetch_data;
    logic [7:0]  fetch_addr;
    logic        core_reset, run, err_overflow;
    logic [6:0]  load_count;

    logic        reset4, ld_valid4, ld_ready4, ld_last4, reload4;
    logic [15:0] ld_data4, fetch_data4;
    logic [7:0]  fetch_addr4;
    logic        core_reset4, run4, err_overflow4;
    logic [2:0]  load_count4;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [5] = '{16'h1028, 16'h1261, 16'h9240, 16'h1261, 16'h1001};

    imem_loader #(.INSTR_W(16), .DEPTH(64), .ADDR_W(8), .RST_HOLD(2),
                  .NOP_WORD(16'h0000)) dut (
        .clka(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .reload(reload),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .core_reset(core_reset), .run(run), .load_count(load_count),
        .err_overflow(err_overflow)
    );

    imem_loader #(.INSTR_W(16), .DEPTH(4), .ADDR_W(8), .RST_HOLD(2),
                  .NOP_WORD(16'h0000)) dut4 (
        .clka(clk), .reset(reset4), .ld_valid(ld_valid4), .ld_ready(ld_ready4),
        .ld_data(ld_data4), .ld_last(ld_last4), .reload(reload4),
        .fetch_addr(fetch_addr4), .fetch_data(fetch_data4),
        .core_reset(core_reset4), .run(run4), .load_count(load_count4),
        .err_overflow(err_overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one fetch address and check the word returned a cycle later.
    task automatic fetch(input logic [7:0] addr, input logic [15:0] exp, input string tag);
        fetch_addr = addr;
        tick();
        check(tag, fetch_data, exp);
    endtask

    task automatic fetch4(input logic [7:0] addr, input logic [15:0] exp, input string tag);
        fetch_addr4 = addr;
        tick();
        check(tag, fetch_data4, exp);
    endtask

    initial begin
        int bad;
        reset = 1'b1; ld_valid = 1'b0; ld_data = 16'h0000; ld_last = 1'b0;
        reload = 1'b0; fetch_addr = 8'd0;
        reset4 = 1'b1; ld_valid4 = 1'b0; ld_data4 = 16'h0000; ld_last4 = 1'b0;
        reload4 = 1'b0; fetch_addr4 = 8'd0;
        tick();
        tick();

        // Reset state
        check("rst_core_reset", core_reset, 1);
        check("rst_run", run, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_load_count", load_count, 0);
        check("rst_err", err_overflow, 0);
        check("rst_fetch", fetch_data, 16'h0000);

        // CLEAR lasts exactly 64 cycles
        reset = 1'b0; reset4 = 1'b0; fetch_addr = 8'd4;
        bad = 0;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (ld_ready !== 1'b0 || core_reset !== 1'b1) bad++;
        end
        check("clear_window", bad, 0);
        check("clear_fetch_nop", fetch_data, 16'h0000);
        tick();
        check("ld_ready_c65", ld_ready, 1);

        // Load five words with a gap cycle between each beat
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 4);
            tick();
            if (i < 4) begin
                ld_valid = 1'b0;
                tick();
            end
        end
        // ld_valid stays high through HOLD with junk data
        ld_last = 1'b0; ld_data = 16'hDEAD;
        check("load_count5", load_count, 5);
        check("hold1_core_reset", core_reset, 1);
        check("hold1_ld_ready", ld_ready, 0);
        tick();
        check("hold2_core_reset", core_reset, 1);
        check("hold2_run", run, 0);
        tick();
        check("run_up", run, 1);
        check("run_core_reset", core_reset, 0);
        check("hold_not_counted", load_count, 5);
        ld_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            fetch(8'(2 * i), prog[i], "fetch_prog");
        end
        fetch(8'd10, 16'h0000, "fetch_unloaded");
        fetch(8'd3, 16'h1261, "fetch_odd_byte");
        fetch(8'd200, 16'h0000, "fetch_out_of_range");
        check("no_overflow", err_overflow, 0);

        // Reload from RUN, fetch on the reload cycle returns NOP
        reload = 1'b1; fetch_addr = 8'd0;
        tick();
        reload = 1'b0;
        check("reload_core_reset", core_reset, 1);
        check("reload_run", run, 0);
        check("reload_count", load_count, 0);
        check("reload_fetch_nop", fetch_data, 16'h0000);
        repeat (63) tick();
        check("reclear_ld_ready0", ld_ready, 0);
        tick();
        check("reclear_ld_ready1", ld_ready, 1);
        ld_valid = 1'b1; ld_data = 16'h00AA; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("reload_count1", load_count, 1);
        tick();
        tick();
        check("reload_run_up", run, 1);
        fetch(8'd0, 16'h00AA, "reload_new_word");
        fetch(8'd2, 16'h0000, "reload_old_gone1");
        fetch(8'd8, 16'h0000, "reload_old_gone4");

        // Reset in the middle of a load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        repeat (64) tick();
        ld_valid = 1'b1; ld_data = 16'h1111;
        tick();
        ld_data = 16'h2222;
        tick();
        ld_valid = 1'b0;
        check("midload_count2", load_count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_count", load_count, 0);
        check("midrst_ld_ready", ld_ready, 0);
        check("midrst_core_reset", core_reset, 1);
        repeat (64) tick();
        check("midrst_ld_ready1", ld_ready, 1);
        ld_valid = 1'b1; ld_data = 16'h0055; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        tick();
        check("midrst_run", run, 1);
        fetch(8'd0, 16'h0055, "midrst_new_word");
        fetch(8'd2, 16'h0000, "midrst_partial_gone");

        // DEPTH=4: five words without ld_last
        check("d4_ld_ready", ld_ready4, 1);
        ld_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data4 = 16'h0A01 + 16'(i);
            tick();
            if (i == 2) check("d4_no_err_yet", err_overflow4, 0);
        end
        check("d4_overflow", err_overflow4, 1);
        check("d4_count4", load_count4, 4);
        check("d4_ld_ready0", ld_ready4, 0);
        ld_data4 = 16'h0A05;
        tick();
        check("d4_fifth_rejected", load_count4, 4);
        check("d4_hold_core_reset", core_reset4, 1);
        tick();
        ld_valid4 = 1'b0;
        check("d4_run", run4, 1);
        fetch4(8'd6, 16'h0A04, "d4_fetch_last");
        fetch4(8'd0, 16'h0A01, "d4_fetch_first");
        fetch4(8'd8, 16'h0000, "d4_fetch_oor");

        // DEPTH=4: exactly four words with ld_last is legal
        reload4 = 1'b1;
        tick();
        reload4 = 1'b0;
        check("d4_reload_err", err_overflow4, 0);
        check("d4_reload_count", load_count4, 0);
        repeat (3) tick();
        check("d4_clear_ld_ready0", ld_ready4, 0);
        tick();
        check("d4_clear_ld_ready1", ld_ready4, 1);
        ld_valid4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data4 = 16'h0B01 + 16'(i);
            ld_last4 = (i == 3);
            tick();
        end
        ld_valid4 = 1'b0; ld_last4 = 1'b0;
        check("d4_exact_no_err", err_overflow4, 0);
        check("d4_exact_count", load_count4, 4);
        check("d4_exact_ld_ready0", ld_ready4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised successor to the 16-bit instruction-load path of the top level.
- Owns the instruction memory. Clears it to NOP on reset, then accepts a program over a valid/ready stream with byte-addressed auto-increment.
- Holds the core in reset for a programmable number of cycles after loading, then releases it.
- Serves core fetches with 1-cycle latency. Supports reload without a global reset.

Parameters:
- INSTR_W, 16, instruction width in bits; multiple of 8.
- DEPTH, 64, number of instruction words; power of two, ≥ 4.
- ADDR_W, 8, byte-address width of fetch_addr; must satisfy 2^ADDR_W ≥ DEPTH*INSTR_W/8.
- RST_HOLD, 2, core_reset cycles held after load completes; ≥ 1.
- NOP_WORD, 0, fill and out-of-range value.

Ports:
- clka  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ld_valid  in  1  load word present
- ld_ready  out  1  block can accept a load word
- ld_data  in  INSTR_W  instruction word
- ld_last  in  1  final word of program; qualified by ld_valid
- reload  in  1  one-cycle pulse; restarts clear/load from RUN
- fetch_addr  in  ADDR_W  core byte address (PC)
- fetch_data  out  INSTR_W  instruction at fetch_addr, 1 cycle later
- core_reset  out  1  reset to core
- run  out  1  core running
- load_count  out  $clog2(DEPTH)+1  words accepted in current load
- err_overflow  out  1  sticky; program exceeded DEPTH

Behaviour:
- One clock (clka); reset is synchronous and active-high.
- On reset, at the next edge: state=CLEAR, clr_ptr=0, wr_ptr=0, core_reset=1, run=0, ld_ready=0, load_count=0, err_overflow=0, fetch_data=NOP_WORD.
- CLEAR:
  - Writes NOP_WORD to mem[clr_ptr] each cycle, clr_ptr++.
  - On the cycle writing DEPTH-1, next state is LOAD.
  - Duration is exactly DEPTH cycles. ld_ready=0.
- LOAD:
  - ld_ready=1.
  - A beat is ld_valid & ld_ready: mem[wr_ptr]=ld_data, wr_ptr++, load_count++.
  - Beat with ld_last=1 → next state HOLD.
  - Beat at wr_ptr==DEPTH-1 with ld_last=0 → word written, err_overflow=1, next state HOLD. Exactly DEPTH words with ld_last on the final one is legal, no error.
  - No beat → stay; no timeout.
- HOLD:
  - ld_ready=0, core_reset=1.
  - Counter runs RST_HOLD cycles, then next state RUN.
  - Beats on ld_valid are ignored, not accepted.
- RUN:
  - core_reset=0, run=1, ld_ready=0.
  - reload=1 → next state CLEAR. core_reset and run update on that same edge. clr_ptr, wr_ptr, load_count and err_overflow clear.
- reload outside RUN: ignored.
- core_reset and run are registered: they change on the edge that enters the new state.
- Fetch:
  - idx = fetch_addr >> log2(INSTR_W/8); the low byte-offset bits are ignored.
  - fetch_data (registered) = mem[idx] if state==RUN and idx<DEPTH, else NOP_WORD.
  - Latency is 1 cycle; the address is sampled every cycle.
  - A fetch on the cycle reload is taken returns NOP_WORD next cycle.
- Memory holds its content across HOLD/RUN. Only CLEAR overwrites it besides LOAD beats.
- reset mid-LOAD or mid-RUN: full restart from CLEAR; the partial program is discarded.

Decomposition:
- Package imem_loader_pkg:
  - state enum {CLEAR, LOAD, HOLD, RUN}, 2 bits
  - localparams for word-offset shift and pointer width
  - default NOP constant
- One sub-module: imem_array, a single-port write / single-port read RAM with synchronous read, parametrised by INSTR_W and DEPTH.
- FSM, pointers and hold counter stay in imem_loader.

Test Plan:
- Reset then idle, DEPTH=64:
  - core_reset=1, ld_ready=0 for exactly 64 cycles after reset release.
  - ld_ready=1 on cycle 65.
  - A fetch of any address returns 0x0000.
- Load 0x1028, 0x1261, 0x9240, 0x1261, 0x1001 (last), RST_HOLD=2:
  - load_count=5, then 2 cycles of core_reset=1, then run=1.
  - fetch_addr=0,2,4,6,8 returns 0x1028, 0x1261, 0x9240, 0x1261, 0x1001 one cycle later.
  - fetch_addr=10 returns 0x0000.
- Backpressure and gaps:
  - ld_valid toggled 1/0 every cycle during LOAD, plus ld_valid held during HOLD.
  - Only LOAD beats are counted; memory matches the accepted sequence.
- Overflow, DEPTH=4:
  - 5 words without ld_last: the first 4 are stored and err_overflow=1 after the 4th; the 5th is never accepted (ld_ready=0).
  - Exactly 4 words with ld_last on the 4th gives err_overflow=0.
- Reload in RUN:
  - Pulse reload: core_reset=1 and run=0 on the next edge; err_overflow and load_count clear.
  - CLEAR refills NOP; old program words then read 0x0000 after the new 1-word load.
- reset asserted mid-LOAD after 2 words: full CLEAR again, load_count=0, and the earlier words are gone.
